// File: rtl/sar_adc_reader_if.sv
// Signal bundle between the SAR ADC controller and its R2R ladder / comparator
// environment. The controller uses the slave side; the driver of start/cmp uses master.
interface sar_adc_reader_if #(
  parameter int WIDTH = 7
);
  logic             start;
  logic             cmp;
  logic [WIDTH-1:0] r2r;
  logic [WIDTH-1:0] sample;
  logic             valid;
  logic             busy;

  modport master (
    output start, cmp,
    input  r2r, sample, valid, busy
  );

  modport slave (
    input  start, cmp,
    output r2r, sample, valid, busy
  );
endinterface

// File: rtl/sar_adc_reader.sv
// Successive-approximation ADC controller driving the shared 7-bit R2R ladder as trial DAC.
// Optional feature macro: SAR_CMP_SYNC_EN (2-flop synchroniser on the comparator input).
module sar_adc_reader #(
  parameter int WIDTH         = 7,
  parameter int SETTLE_CYCLES = 8
) (
  input logic            clk,
  input logic            reset,
  sar_adc_reader_if.slave bus
);

  localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int CW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

  localparam logic [IW-1:0]    IDX_ONE     = IW'(1);
  localparam logic [IW-1:0]    IDX_ZERO    = IW'(0);
  localparam logic [IW-1:0]    IDX_MSB     = IW'(WIDTH - 1);
  localparam logic [CW-1:0]    CNT_ONE     = CW'(1);
  localparam logic [CW-1:0]    CNT_ZERO    = CW'(0);
  localparam logic [CW-1:0]    SETTLE_LAST = CW'(SETTLE_CYCLES - 1);
  localparam logic [WIDTH-1:0] CODE_ZERO   = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] CODE_MSB    = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_DECIDE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] trial_q, trial_d;
  logic [WIDTH-1:0] sample_q, sample_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             valid_q, valid_d;
  logic             busy_q, busy_d;
  logic             cmp_q;

`ifdef SAR_CMP_SYNC_EN
  logic cmp_meta_q;
  logic cmp_sync_q;

  // Two-stage synchroniser; its latency is hidden inside the settle window.
  always_ff @(posedge clk) begin
    if (reset) begin
      cmp_meta_q <= 1'b0;
      cmp_sync_q <= 1'b0;
    end else begin
      cmp_meta_q <= bus.cmp;
      cmp_sync_q <= cmp_meta_q;
    end
  end

  assign cmp_q = cmp_sync_q;
`else
  assign cmp_q = bus.cmp;
`endif

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      trial_q  <= CODE_ZERO;
      sample_q <= CODE_ZERO;
      idx_q    <= IDX_ZERO;
      cnt_q    <= CNT_ZERO;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      trial_q  <= trial_d;
      sample_q <= sample_d;
      idx_q    <= idx_d;
      cnt_q    <= cnt_d;
      valid_q  <= valid_d;
      busy_q   <= busy_d;
    end
  end

  // Next-state logic: binary search over the ladder code, one bit per SETTLE+DECIDE pass.
  always_comb begin
    state_d  = state_q;
    trial_d  = trial_q;
    sample_d = sample_q;
    idx_d    = idx_q;
    cnt_d    = cnt_q;
    valid_d  = 1'b0;
    busy_d   = busy_q;

    case (state_q)
      ST_IDLE: begin
        busy_d = 1'b0;
        if (bus.start) begin
          trial_d = CODE_MSB;
          idx_d   = IDX_MSB;
          cnt_d   = CNT_ZERO;
          busy_d  = 1'b1;
          state_d = ST_SETTLE;
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_SETTLE: begin
        cnt_d = cnt_q + CNT_ONE;
        if (cnt_q == SETTLE_LAST) begin
          state_d = ST_DECIDE;
        end else begin
          state_d = ST_SETTLE;
        end
      end

      ST_DECIDE: begin
        // Comparator low means the trial overshot the input: drop this bit.
        if (!cmp_q) begin
          trial_d[idx_q] = 1'b0;
        end else begin
          trial_d[idx_q] = trial_q[idx_q];
        end
        if (idx_q != IDX_ZERO) begin
          trial_d[idx_q - IDX_ONE] = 1'b1;
          idx_d   = idx_q - IDX_ONE;
          cnt_d   = CNT_ZERO;
          state_d = ST_SETTLE;
        end else begin
          sample_d = trial_d;
          valid_d  = 1'b1;
          busy_d   = 1'b0;
          state_d  = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  assign bus.r2r    = trial_q;
  assign bus.sample = sample_q;
  assign bus.valid  = valid_q;
  assign bus.busy   = busy_q;

endmodule

// File: tb/tb_sar_adc_reader.sv
// Self-checking bench for sar_adc_reader: ideal comparator (vin >= r2r) and an
// arithmetic model of the expected trial codes, timing and outputs.
module tb_sar_adc_reader;

  localparam int W = 7;
`ifdef SAR_CMP_SYNC_EN
  localparam int S = 3;
`else
  localparam int S = 8;
`endif
  localparam int L = W * (S + 1);

  logic clk;
  logic reset;
  int   vin;
  int   pass_cnt;
  int   chk_cnt;
  int   last_sample;

  sar_adc_reader_if #(.WIDTH(W)) bus ();

  assign bus.cmp = (vin >= int'(bus.r2r));

  sar_adc_reader #(.WIDTH(W), .SETTLE_CYCLES(S)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Trial code at step b: higher bits already equal vin's, current bit set, lower bits zero.
  function automatic int trial_of(input int v, input int b);
    int p;
    p = W - 1 - b;
    return ((v >> (p + 1)) << (p + 1)) + (1 << p);
  endfunction

  // One conversion of v, checked every cycle from the accept edge to the valid cycle.
  task automatic conv(input int v, input bit prestarted, input bit pulse_busy,
                      input bit chain, input int next_v);
    int exp_r2r;
    int exp_sample;
    bit exp_busy;
    bit exp_valid;
    if (!prestarted) begin
      @(negedge clk);
      vin       = v;
      bus.start = 1'b1;
    end
    for (int o = 0; o <= L; o++) begin
      @(posedge clk);
      @(negedge clk);
      exp_valid  = (o == L);
      exp_busy   = (o < L);
      exp_r2r    = (o < L) ? trial_of(v, o / (S + 1)) : v;
      exp_sample = (o < L) ? last_sample : v;
      chk_cnt++;
      if (bus.r2r !== W'(exp_r2r))
        $display("FAIL r2r vin=%0d cyc=%0d got=%0d exp=%0d", v, o, bus.r2r, exp_r2r);
      else pass_cnt++;
      chk_cnt++;
      if (bus.busy !== exp_busy)
        $display("FAIL busy vin=%0d cyc=%0d got=%0b exp=%0b", v, o, bus.busy, exp_busy);
      else pass_cnt++;
      chk_cnt++;
      if (bus.valid !== exp_valid)
        $display("FAIL valid vin=%0d cyc=%0d got=%0b exp=%0b", v, o, bus.valid, exp_valid);
      else pass_cnt++;
      chk_cnt++;
      if (bus.sample !== W'(exp_sample))
        $display("FAIL sample vin=%0d cyc=%0d got=%0d exp=%0d", v, o, bus.sample, exp_sample);
      else pass_cnt++;
      bus.start = pulse_busy && (o < L) && ((o % 3) == 1);
      if (o == L && chain) begin
        bus.start = 1'b1;
        vin       = next_v;
      end
    end
    last_sample = v;
  endtask

  task automatic test_reset;
    reset     = 1'b1;
    bus.start = 1'b0;
    repeat (2) @(negedge clk);
    chk_cnt++;
    if ({bus.r2r, bus.sample, bus.valid, bus.busy} !== {W'(0), W'(0), 1'b0, 1'b0})
      $display("FAIL reset_outputs got r2r=%0d sample=%0d valid=%0b busy=%0b exp all 0",
               bus.r2r, bus.sample, bus.valid, bus.busy);
    else pass_cnt++;
    reset = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      chk_cnt++;
      if (bus.busy !== 1'b0 || bus.valid !== 1'b0 || bus.r2r !== W'(0))
        $display("FAIL idle cyc=%0d got busy=%0b valid=%0b r2r=%0d exp 0/0/0",
                 i, bus.busy, bus.valid, bus.r2r);
      else pass_cnt++;
    end
  endtask

  task automatic test_single;
    conv(90, 1'b0, 1'b0, 1'b0, 0);
  endtask

  task automatic test_back_to_back;
    conv(0,   1'b0, 1'b0, 1'b1, 127);
    conv(127, 1'b1, 1'b0, 1'b1, 33);
    conv(33,  1'b1, 1'b0, 1'b0, 0);
  endtask

  task automatic test_busy_ignore;
    conv(45, 1'b0, 1'b1, 1'b0, 0);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk_cnt++;
      if (bus.valid !== 1'b0 || bus.busy !== 1'b0 || bus.sample !== W'(45))
        $display("FAIL busy_ignore_tail cyc=%0d got valid=%0b busy=%0b sample=%0d exp 0/0/45",
                 i, bus.valid, bus.busy, bus.sample);
      else pass_cnt++;
    end
  endtask

  task automatic test_reset_mid;
    @(negedge clk);
    vin       = 50;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (29) @(negedge clk);
    chk_cnt++;
    if (bus.busy !== 1'b1)
      $display("FAIL reset_mid_pre got busy=%0b exp=1", bus.busy);
    else pass_cnt++;
    reset = 1'b1;
    @(negedge clk);
    chk_cnt++;
    if ({bus.r2r, bus.sample, bus.valid, bus.busy} !== {W'(0), W'(0), 1'b0, 1'b0})
      $display("FAIL reset_mid got r2r=%0d sample=%0d valid=%0b busy=%0b exp all 0",
               bus.r2r, bus.sample, bus.valid, bus.busy);
    else pass_cnt++;
    reset       = 1'b0;
    last_sample = 0;
    conv(100, 1'b0, 1'b0, 1'b0, 0);
  endtask

  task automatic test_random;
    for (int i = 0; i < 5; i++) begin
      conv(int'($urandom_range(0, (1 << W) - 1)), 1'b0, 1'b0, 1'b0, 0);
    end
  endtask

  initial begin
    pass_cnt    = 0;
    chk_cnt     = 0;
    last_sample = 0;
    vin         = 0;
    reset       = 1'b1;
    bus.start   = 1'b0;
    test_reset;
    test_single;
    test_back_to_back;
    test_busy_ignore;
    test_reset_mid;
    test_random;
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
